// File: rtl/sort_seq.sv
// Sequential 4-entry sorter: load four words, odd-even transposition sort in place, drain in order.
// Define SORT_SEQ_DESCEND_EN for largest-first output; the default build sorts smallest-first.
module sort_seq #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    if (N != 4) begin : g_bad_n
        $error("sort_seq: N must be 4, got %0d", N);
    end

`ifdef SORT_SEQ_DESCEND_EN
    localparam bit DESCEND = 1'b1;
`else
    localparam bit DESCEND = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_data [4];
    logic             r_inReady;
    logic             r_outValid;
    logic [WIDTH-1:0] r_outData;
    logic             r_outLast;
    logic             r_busy;

    logic [WIDTH-1:0] w_pass [4];
    logic [1:0]       w_cntNext;

    // Strict compare so equal words never move past each other, keeping the sort stable.
    function automatic logic f_swap(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (DESCEND) begin
            return a < b;
        end
        return a > b;
    endfunction

    assign w_cntNext = r_cnt + 2'd1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_pass[i] = r_data[i];
        end
        if (!r_cnt[0]) begin
            if (f_swap(r_data[0], r_data[1])) begin
                w_pass[0] = r_data[1];
                w_pass[1] = r_data[0];
            end
            if (f_swap(r_data[2], r_data[3])) begin
                w_pass[2] = r_data[3];
                w_pass[3] = r_data[2];
            end
        end else begin
            if (f_swap(r_data[1], r_data[2])) begin
                w_pass[1] = r_data[2];
                w_pass[2] = r_data[1];
            end
        end
    end

    // All outputs are registered; out_data is preloaded from the final pass so DRAIN has no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_LOAD;
            r_cnt      <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_data[i] <= '0;
            end
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_outLast  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid && r_inReady) begin
                        r_data[r_cnt] <= in_data;
                        if (r_cnt == 2'd3) begin
                            r_cnt     <= 2'd0;
                            r_state   <= S_SORT;
                            r_inReady <= 1'b0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_cnt <= w_cntNext;
                        end
                    end
                end
                S_SORT: begin
                    for (int i = 0; i < 4; i++) begin
                        r_data[i] <= w_pass[i];
                    end
                    if (r_cnt == 2'd3) begin
                        r_cnt      <= 2'd0;
                        r_state    <= S_DRAIN;
                        r_outValid <= 1'b1;
                        r_outData  <= w_pass[0];
                        r_outLast  <= 1'b0;
                    end else begin
                        r_cnt <= w_cntNext;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_cnt == 2'd3) begin
                            r_cnt      <= 2'd0;
                            r_state    <= S_LOAD;
                            r_outValid <= 1'b0;
                            r_outData  <= '0;
                            r_outLast  <= 1'b0;
                            r_busy     <= 1'b0;
                            r_inReady  <= 1'b1;
                        end else begin
                            r_cnt     <= w_cntNext;
                            r_outData <= r_data[w_cntNext];
                            r_outLast <= (r_cnt == 2'd2);
                        end
                    end
                end
                default: begin
                    r_state    <= S_LOAD;
                    r_cnt      <= 2'd0;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                    r_outData  <= '0;
                    r_outLast  <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign out_last  = r_outLast;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sort_seq.sv
// Scoreboard bench for sort_seq: stimulus pushes expected words, a monitor thread pops and compares.
// Build with SORT_SEQ_DESCEND_EN defined to check the largest-first variant.
module tb_sort_seq;

`ifdef SORT_SEQ_DESCEND_EN
    localparam bit DESCEND = 1'b1;
`else
    localparam bit DESCEND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int         nChecks = 0;
    int         nFails = 0;
    logic [8:0] expQ [$];
    int         readyMode = 0;

    always #5 clk = ~clk;

    sort_seq #(.WIDTH(8), .N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Words are given smallest-first; descending builds expect them reversed.
    task automatic pushSorted(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({(i == 3), v[DESCEND ? 3 - i : i]});
        end
    endtask

    // Stable insertion sort reference for the random batches.
    task automatic pushModel(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        logic [7:0] v [4];
        logic [7:0] t;
        int j;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 1; i < 4; i++) begin
            j = i;
            while (j > 0 && (DESCEND ? (v[j] > v[j-1]) : (v[j] < v[j-1]))) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
                j--;
            end
        end
        for (int i = 0; i < 4; i++) begin
            expQ.push_back({(i == 3), v[i]});
        end
    endtask

    task automatic loadWord(input logic [7:0] w, input int gap);
        bit ok;
        int t;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = w;
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 100) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            t++;
        end
        if (!ok) checkOutput("load_timeout", 32'(in_ready), 1);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic applyStimulus(input logic [7:0] w0, input logic [7:0] w1,
                                 input logic [7:0] w2, input logic [7:0] w3, input int gap);
        loadWord(w0, gap);
        loadWord(w1, gap);
        loadWord(w2, gap);
        loadWord(w3, gap);
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while (expQ.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        checkOutput("drain_complete", 32'(expQ.size()), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rstPulse();
        @(negedge clk);
        #2;
        rst = 1'b1;
        expQ.delete();
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 1);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_out_last", 32'(out_last), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prevHold;
        logic [7:0] prevData;
        logic [8:0] e;
        int k;
        logic [7:0] r0, r1, r2, r3;

        fork
            // Monitor: compares each accepted output word and checks hold stability.
            begin
                prevHold = 1'b0;
                prevData = 8'd0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prevHold = 1'b0;
                    end else begin
                        if (prevHold) begin
                            checkOutput("hold_valid", 32'(out_valid), 1);
                            checkOutput("hold_data", 32'(out_data), 32'(prevData));
                        end
                        if (out_valid && out_ready) begin
                            if (expQ.size() == 0) begin
                                checkOutput("unexpected_output", 32'(out_valid), 0);
                            end else begin
                                e = expQ.pop_front();
                                checkOutput("out_data", 32'(out_data), 32'(e[7:0]));
                                checkOutput("out_last", 32'(out_last), 32'(e[8]));
                            end
                        end
                        prevHold = out_valid && !out_ready;
                        prevData = out_data;
                    end
                end
            end
            begin
                forever begin
                    @(posedge clk);
                    #1;
                    case (readyMode)
                        0:       out_ready = 1'b1;
                        1:       out_ready = ~out_ready;
                        default: out_ready = 1'b0;
                    endcase
                end
            end
            begin
                #200000;
                $display("[TB] FAIL watchdog: simulation time limit reached");
                $fatal(1, "[TB] watchdog");
            end
        join_none

        // Reset state
        #1 rst = 1'b1;
        #1;
        checkOutput("init_in_ready", 32'(in_ready), 1);
        checkOutput("init_out_valid", 32'(out_valid), 0);
        checkOutput("init_out_data", 32'(out_data), 0);
        checkOutput("init_out_last", 32'(out_last), 0);
        checkOutput("init_busy", 32'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic batch with first-output latency
        pushSorted(8'd3, 8'd17, 8'd99, 8'd200);
        applyStimulus(8'd200, 8'd17, 8'd99, 8'd3, 0);
        checkOutput("sort_busy", 32'(busy), 1);
        checkOutput("sort_in_ready", 32'(in_ready), 0);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                k = i;
                break;
            end
        end
        checkOutput("first_out_latency", 32'(k), 4);
        waitDrain();

        // Ties and extreme values
        pushSorted(8'd0, 8'd0, 8'd255, 8'd255);
        applyStimulus(8'd255, 8'd0, 8'd255, 8'd0, 0);
        waitDrain();
        pushSorted(8'd7, 8'd7, 8'd7, 8'd7);
        applyStimulus(8'd7, 8'd7, 8'd7, 8'd7, 0);
        waitDrain();

        // Gapped input and toggling output backpressure
        readyMode = 1;
        pushSorted(8'd3, 8'd17, 8'd99, 8'd200);
        applyStimulus(8'd200, 8'd17, 8'd99, 8'd3, 2);
        waitDrain();
        readyMode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while stalled in DRAIN drops the batch
        readyMode = 2;
        applyStimulus(8'd1, 8'd2, 8'd3, 8'd4, 0);
        repeat (8) @(posedge clk);
        #1;
        checkOutput("stall_out_valid", 32'(out_valid), 1);
        rstPulse();
        readyMode = 0;
        pushSorted(8'd10, 8'd20, 8'd30, 8'd40);
        applyStimulus(8'd40, 8'd30, 8'd20, 8'd10, 1);
        waitDrain();

        // Reset during partial LOAD and during SORT
        loadWord(8'd9, 0);
        loadWord(8'd8, 0);
        rstPulse();
        applyStimulus(8'd9, 8'd8, 8'd6, 8'd5, 0);
        @(posedge clk);
        #1;
        checkOutput("mid_sort_busy", 32'(busy), 1);
        rstPulse();
        pushSorted(8'd1, 8'd2, 8'd3, 8'd4);
        applyStimulus(8'd4, 8'd3, 8'd2, 8'd1, 0);
        waitDrain();

        // Random batches against a stable reference sort
        for (int b = 0; b < 20; b++) begin
            r0 = 8'($urandom_range(0, 255));
            r1 = 8'($urandom_range(0, 255));
            r2 = 8'($urandom_range(0, 255));
            r3 = 8'($urandom_range(0, 255));
            readyMode = (b % 4 == 3) ? 1 : 0;
            pushModel(r0, r1, r2, r3);
            applyStimulus(r0, r1, r2, r3, b % 2);
            waitDrain();
        end
        readyMode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
